// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI4 memory responder for the 0x8000_0000 main-memory window.
//
// Independent write and read FSMs, one burst each in flight. FIXED, INCR and WRAP
// bursts of up to 256 beats on a 32-bit bus with byte strobes. Illegal bursts and
// out-of-range beats answer SLVERR.
//
// Parameters:
//   ADDR_BASE  byte address of memory word 0
//   MEM_WORDS  memory depth in 32-bit words (power of two)
//
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   S_AXI_AW*  (ADDR/LEN/SIZE/BURST, VALID/READY)   write address channel
//   S_AXI_W*   (DATA/STRB/LAST, VALID/READY)        write data channel
//   S_AXI_B*   (RESP, VALID/READY)                  write response channel
//   S_AXI_AR*  (ADDR/LEN/SIZE/BURST, VALID/READY)   read address channel
//   S_AXI_R*   (DATA/RESP/LAST, VALID/READY)        read data channel
//
// Build option:
//   AXI_MEM_SLAVE_WLAST_CHECK_EN  when defined, a W beat whose WLAST disagrees with
//   the beat count poisons the burst (BRESP=SLVERR, no further writes). Termination
//   is always by AWLEN.
module axi_mem_slave #(
    parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
    parameter int unsigned MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [7:0]  S_AXI_AWLEN,
    input  logic [2:0]  S_AXI_AWSIZE,
    input  logic [1:0]  S_AXI_AWBURST,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WLAST,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [7:0]  S_AXI_ARLEN,
    input  logic [2:0]  S_AXI_ARSIZE,
    input  logic [1:0]  S_AXI_ARBURST,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);

    localparam int unsigned IdxW = $clog2(MEM_WORDS);
    localparam logic [1:0] RespOkay = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstWrap = 2'b10;

    // Whole-burst legality, decided once at the address handshake.
    function automatic logic burst_bad(input logic [2:0] size, input logic [7:0] len,
                                       input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size > 3'd2) || (burst == 2'b11) || ((burst == BurstWrap) && !wrap_len_ok);
    endfunction

    function automatic logic addr_ok(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - ADDR_BASE;
        return (addr >= ADDR_BASE) && ((off >> 2) < MEM_WORDS);
    endfunction

    function automatic logic [IdxW-1:0] addr_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - ADDR_BASE;
        return off[IdxW+1:2];
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst);
        logic [31:0] bytes, aligned, wmask, res;
        bytes   = 32'd1 << size;
        aligned = addr & ~(bytes - 32'd1);
        // WRAP lengths are restricted to 2/4/8/16 beats, so the window is a power of two.
        wmask   = (({24'd0, len} + 32'd1) << size) - 32'd1;
        case (burst)
            BurstFixed: res = addr;
            BurstWrap:  res = (addr & ~wmask) | ((aligned + bytes) & wmask);
            default:    res = aligned + bytes;
        endcase
        return res;
    endfunction

    logic [31:0] mem [MEM_WORDS];

    // ---------------------------------------------------------------- write side
    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

    w_state_e    w_state_q, w_state_d;
    logic [31:0] waddr_q, waddr_d;
    logic [7:0]  wlen_q, wlen_d;
    logic [2:0]  wsize_q, wsize_d;
    logic [1:0]  wburst_q, wburst_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        wbad_q, wbad_d;   // burst poisoned: suppress all further writes
    logic        werr_q, werr_d;   // burst will answer SLVERR
    logic        wbad_beat;
    logic        mem_we;
    logic [IdxW-1:0] mem_widx;
    logic        awready_q, wready_q, bvalid_q;
    logic [1:0]  bresp_q;

`ifndef AXI_MEM_SLAVE_WLAST_CHECK_EN
    logic unused_wlast;
    assign unused_wlast = S_AXI_WLAST;
`endif

    always_comb begin
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wsize_d   = wsize_q;
        wburst_d  = wburst_q;
        wcnt_d    = wcnt_q;
        wbad_d    = wbad_q;
        werr_d    = werr_q;
        wbad_beat = wbad_q;
        mem_we    = 1'b0;
        mem_widx  = addr_idx(waddr_q);
        case (w_state_q)
            WIdle: begin
                if (S_AXI_AWVALID && awready_q) begin
                    waddr_d   = S_AXI_AWADDR;
                    wlen_d    = S_AXI_AWLEN;
                    wsize_d   = S_AXI_AWSIZE;
                    wburst_d  = S_AXI_AWBURST;
                    wcnt_d    = 8'd0;
                    wbad_d    = burst_bad(S_AXI_AWSIZE, S_AXI_AWLEN, S_AXI_AWBURST);
                    werr_d    = wbad_d;
                    w_state_d = WData;
                end
            end
            WData: begin
                if (S_AXI_WVALID && wready_q) begin
`ifdef AXI_MEM_SLAVE_WLAST_CHECK_EN
                    if (S_AXI_WLAST != (wcnt_q == wlen_q)) begin
                        wbad_beat = 1'b1;
                    end
`endif
                    mem_we  = !wbad_beat && addr_ok(waddr_q);
                    wbad_d  = wbad_beat;
                    werr_d  = werr_q || wbad_beat || !addr_ok(waddr_q);
                    waddr_d = next_addr(waddr_q, wsize_q, wlen_q, wburst_q);
                    wcnt_d  = wcnt_q + 8'd1;
                    if (wcnt_q == wlen_q) begin
                        w_state_d = WResp;
                    end
                end
            end
            WResp: begin
                if (S_AXI_BREADY && bvalid_q) begin
                    w_state_d = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    // Handshake outputs are registered from the next state so that they come up
    // one edge after reset release rather than during reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state_q <= WIdle;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wcnt_q    <= '0;
            wbad_q    <= 1'b0;
            werr_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RespOkay;
        end else begin
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wcnt_q    <= wcnt_d;
            wbad_q    <= wbad_d;
            werr_q    <= werr_d;
            awready_q <= (w_state_d == WIdle);
            wready_q  <= (w_state_d == WData);
            bvalid_q  <= (w_state_d == WResp);
            bresp_q   <= ((w_state_d == WResp) && werr_d) ? RespSlvErr : RespOkay;
        end
    end

    // Memory contents survive reset; mem_we is already gated by the reset FSM state.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    mem[mem_widx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

    // ----------------------------------------------------------------- read side
    typedef enum logic [0:0] {RIdle, RData} r_state_e;

    r_state_e    r_state_q, r_state_d;
    logic [31:0] raddr_q, raddr_d;
    logic [7:0]  rlen_q, rlen_d;
    logic [2:0]  rsize_q, rsize_d;
    logic [1:0]  rburst_q, rburst_d;
    logic [7:0]  rcnt_q, rcnt_d;
    logic        rbad_q, rbad_d;
    logic        rload;
    logic [31:0] rload_addr;
    logic        rload_bad;
    logic        arready_q, rvalid_q, rlast_q;
    logic [1:0]  rresp_q;
    logic [31:0] rdata_q;

    always_comb begin
        r_state_d  = r_state_q;
        raddr_d    = raddr_q;
        rlen_d     = rlen_q;
        rsize_d    = rsize_q;
        rburst_d   = rburst_q;
        rcnt_d     = rcnt_q;
        rbad_d     = rbad_q;
        rload      = 1'b0;
        rload_addr = raddr_q;
        rload_bad  = rbad_q;
        case (r_state_q)
            RIdle: begin
                if (S_AXI_ARVALID && arready_q) begin
                    raddr_d    = S_AXI_ARADDR;
                    rlen_d     = S_AXI_ARLEN;
                    rsize_d    = S_AXI_ARSIZE;
                    rburst_d   = S_AXI_ARBURST;
                    rcnt_d     = 8'd0;
                    rbad_d     = burst_bad(S_AXI_ARSIZE, S_AXI_ARLEN, S_AXI_ARBURST);
                    rload      = 1'b1;
                    rload_addr = S_AXI_ARADDR;
                    rload_bad  = rbad_d;
                    r_state_d  = RData;
                end
            end
            RData: begin
                if (S_AXI_RREADY && rvalid_q) begin
                    if (rcnt_q == rlen_q) begin
                        r_state_d = RIdle;
                    end else begin
                        raddr_d    = next_addr(raddr_q, rsize_q, rlen_q, rburst_q);
                        rcnt_d     = rcnt_q + 8'd1;
                        rload      = 1'b1;
                        rload_addr = raddr_d;
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    // The beat is captured from mem before any same-edge write lands: old data wins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_q <= RIdle;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rcnt_q    <= '0;
            rbad_q    <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RespOkay;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rcnt_q    <= rcnt_d;
            rbad_q    <= rbad_d;
            arready_q <= (r_state_d == RIdle);
            rvalid_q  <= (r_state_d == RData);
            if (rload) begin
                rlast_q <= (rcnt_d == rlen_d);
                if (!rload_bad && addr_ok(rload_addr)) begin
                    rdata_q <= mem[addr_idx(rload_addr)];
                    rresp_q <= RespOkay;
                end else begin
                    rdata_q <= '0;
                    rresp_q <= RespSlvErr;
                end
            end
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;

endmodule

// File: doc/axi_mem_slave.md
# axi_mem_slave

AXI4 (full) responder modelling the main-memory target behind slave port S0 of the SoC interconnect (0x8000_0000 window). It accepts one write burst and one read burst at a time, each handled by its own independent FSM. It supports FIXED, INCR and WRAP bursts of up to 256 beats on a 32-bit data bus, with byte-strobed writes. Protocol violations and out-of-range addresses return SLVERR.

## Interface
- ADDR_BASE, 32'h8000_0000, byte address of memory word 0.
- MEM_WORDS, 4096, depth in 32-bit words; must be a power of two.
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR / AWLEN / AWSIZE / AWBURST  in  32/8/3/2  write address, burst length minus 1, log2 bytes per beat, burst type.
- S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
- S_AXI_WDATA / WSTRB / WLAST / WVALID  in  32/4/1/1; S_AXI_WREADY out 1.
- S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
- S_AXI_ARADDR / ARLEN / ARSIZE / ARBURST  in  32/8/3/2; S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
- S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RLAST out 1; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
- There are no LOCK, CACHE, PROT, REGION, QOS or ID ports; the interconnect drops these signals for S0.

## Operation
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: AWREADY=1. An AW handshake latches addr, len, size and burst, clears the beat counter and error flag, and moves to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes the bytes whose WSTRB bit is set to word (addr-ADDR_BASE)>>2, unless the burst is errored or the word is out of range. The address then advances.
  - When beat counter == len on a W handshake, the FSM moves to W_RESP.
  - W_RESP: BVALID=1, BRESP is OKAY (2'b00) or SLVERR (2'b10). A B handshake returns the FSM to W_IDLE.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. An AR handshake latches the burst and registers RDATA=mem[word0].
  - R_DATA: RVALID=1, RLAST=1 when beat counter == len. An R handshake on a non-last beat registers the next beat's data and keeps RVALID high. An R handshake on the last beat returns the FSM to R_IDLE.
- Address advance, with bytes = 1<<size:
  - FIXED: address held.
  - INCR: next = (addr & ~(bytes-1)) + bytes.
  - WRAP: increment within a (len+1)*bytes-aligned window, wrapping to the window base.
  - 4 KB boundary crossing is not checked.
- Burst errors are sticky for the whole burst. No memory is written, reads return 0, and the response is SLVERR on every beat when:
  - size > 2, or
  - burst == 2'b11, or
  - WRAP with len not in {1,3,7,15}.
- Per-beat range error: address < ADDR_BASE, or word index >= MEM_WORDS.
  - Write: that beat is not written and the burst BRESP is SLVERR.
  - Read: RDATA=0 and RRESP=SLVERR for that beat only.
- The read and write channels are fully independent and may be active in the same cycle.

## Timing
- Reset values: AWREADY=0, WREADY=0, BVALID=0, BRESP=0, ARREADY=0, RVALID=0, RRESP=0, RLAST=0, RDATA=0.
- Both FSMs enter IDLE, and AWREADY/ARREADY rise on the first clk edge after resetn deasserts.
- Memory contents are not reset.
- Write latencies:
  - AW handshake at edge T: WREADY=1 from T+1.
  - Last W handshake at T: BVALID=1 from T+1.
  - B handshake at T: AWREADY=1 from T+1.
- Read latencies:
  - AR handshake at T: RVALID=1 with beat 0 from T+1.
  - With RREADY held high, one beat per cycle with no bubbles.
  - RLAST handshake at T: ARREADY=1 from T+1.
- Once asserted, BVALID/RVALID and their payload stay stable until the handshake completes.
- Read/write collision: a read beat registered in the same cycle as a write to the same word returns the old data.
- Mid-operation reset: in-flight bursts are abandoned, bytes already written remain, and no response is issued.

## Configuration
- AXI_MEM_SLAVE_WLAST_CHECK_EN defined:
  - Any W beat with WLAST != (counter == len) sets the burst error flag, giving BRESP=SLVERR.
  - Beats already accepted remain written.
  - Termination stays count-based.
- Undefined: WLAST is ignored and termination is purely by AWLEN.

## Test plan
- INCR write at 0x8000_0010, len=3, size=2, data 0x11..0x44, WSTRB=4'hF -> BRESP=OKAY one cycle after beat 3. INCR read of the same burst -> 0x11,0x22,0x33,0x44 with RLAST on beat 3, RRESP=OKAY.
- WRAP read at 0x8000_0038, len=3, size=2 -> words read in order 0x38, 0x3C, 0x30, 0x34. Same start address with len=2 -> four... no: three beats, all RRESP=SLVERR, RDATA=0.
- Byte write at 0x8000_0001, WSTRB=4'b0010, WDATA=0xAABBCCDD, over word 0x0 -> read returns 0x0000CC00; other bytes unchanged.
- Read crossing the top of memory: ARADDR=ADDR_BASE+4*MEM_WORDS-4, len=1 -> beat 0 OKAY, beat 1 RRESP=SLVERR with RDATA=0. Write with AWSIZE=3 -> BRESP=SLVERR, memory unchanged.
- With the macro defined, WLAST asserted on beat 1 of a len=3 burst -> BRESP=SLVERR after beat 3. Without the macro -> BRESP=OKAY.
- Concurrent write and read bursts with random BREADY/RREADY stalls -> payload stable while VALID is high. Then resetn pulsed mid-burst -> all outputs return to their reset values, and AWREADY=ARREADY=1 one cycle after release.
